// File: rtl/sha256_id_issuer.sv
// Packet ID issuer and credit controller at the head of the SHA-256 pipeline.
// Each packet gets a 6-bit wrapping ID that tags all of its blocks toward the hash
// engine. The ID is also pushed once to the ID buffer FIFO. A credit counter limits
// how many packets can be in flight, so the validator's wrap comparison stays
// unambiguous.
module sha256_id_issuer #(
    parameter int unsigned MAX_OUTSTANDING = 31
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en_i,
    input  logic         sync_rst_i,
    input  logic [5:0]   cfg_seed_i,
    input  logic         cfg_seed_load_i,
    input  logic [511:0] msg_in_data_i,
    input  logic         msg_in_last_i,
    input  logic         msg_in_valid_i,
    output logic         msg_in_ready_o,
    output logic [511:0] msg_out_data_o,
    output logic [5:0]   msg_out_id_o,
    output logic         msg_out_last_o,
    output logic         msg_out_valid_o,
    input  logic         msg_out_ready_i,
    output logic [5:0]   id_out_o,
    output logic         id_out_last_o,
    output logic         id_out_valid_o,
    input  logic         id_out_ready_i,
    input  logic         hash_done_i,
    output logic [5:0]   status_next_id_o,
    output logic [5:0]   status_outstanding_o,
    output logic [1:0]   status_err_o,
    input  logic         status_clear_i
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    localparam logic [5:0] MaxOut = 6'(MAX_OUTSTANDING);

    state_e         state_q;
    logic [5:0]     next_id_q;
    logic [5:0]     cur_id_q;
    logic [5:0]     outstanding_q;
    logic [511:0]   msg_out_data_q;
    logic [5:0]     msg_out_id_q;
    logic           msg_out_last_q;
    logic           msg_out_valid_q;
    logic [5:0]     id_out_q;
    logic           id_out_valid_q;
    logic [1:0]     err_q;

    logic slot_free;
    logic credit_ok;
    logic id_slot_ok;
    logic seed_req;
    logic seed_ok;
    logic ready;
    logic accept;
    logic alloc;

    // Handshake qualification; a seed load request in IDLE blocks allocation that cycle.
    always_comb begin
        slot_free  = !msg_out_valid_q || msg_out_ready_i;
        credit_ok  = outstanding_q < MaxOut;
        id_slot_ok = !id_out_valid_q || id_out_ready_i;
        seed_req   = en_i && cfg_seed_load_i;
        seed_ok    = (state_q == StIdle) && (outstanding_q == 6'd0) &&
                     !id_out_valid_q && !msg_out_valid_q;
        if (state_q == StIdle) begin
            ready = en_i && slot_free && credit_ok && id_slot_ok && !seed_req;
        end else begin
            ready = en_i && slot_free;
        end
        accept = msg_in_valid_i && ready;
        alloc  = accept && (state_q == StIdle);
    end

    // Packet FSM, credit counter, ID allocation and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= StIdle;
            next_id_q       <= 6'd0;
            cur_id_q        <= 6'd0;
            outstanding_q   <= 6'd0;
            msg_out_data_q  <= '0;
            msg_out_id_q    <= 6'd0;
            msg_out_last_q  <= 1'b0;
            msg_out_valid_q <= 1'b0;
            id_out_q        <= 6'd0;
            id_out_valid_q  <= 1'b0;
            err_q           <= 2'b00;
        end else if (sync_rst_i) begin
            state_q         <= StIdle;
            next_id_q       <= 6'd0;
            cur_id_q        <= 6'd0;
            outstanding_q   <= 6'd0;
            msg_out_data_q  <= '0;
            msg_out_id_q    <= 6'd0;
            msg_out_last_q  <= 1'b0;
            msg_out_valid_q <= 1'b0;
            id_out_q        <= 6'd0;
            id_out_valid_q  <= 1'b0;
            err_q           <= 2'b00;
        end else if (en_i) begin
            if (accept) begin
                msg_out_data_q  <= msg_in_data_i;
                msg_out_last_q  <= msg_in_last_i;
                msg_out_id_q    <= alloc ? next_id_q : cur_id_q;
                msg_out_valid_q <= 1'b1;
                state_q         <= msg_in_last_i ? StIdle : StStream;
            end else if (msg_out_ready_i) begin
                msg_out_valid_q <= 1'b0;
            end

            if (alloc) begin
                id_out_q       <= next_id_q;
                id_out_valid_q <= 1'b1;
                cur_id_q       <= next_id_q;
                next_id_q      <= next_id_q + 6'd1;
            end else begin
                if (id_out_ready_i) begin
                    id_out_valid_q <= 1'b0;
                end
                if (seed_req && seed_ok) begin
                    next_id_q <= cfg_seed_i;
                end
            end

            // A simultaneous allocation and credit return cancel out.
            if (alloc && !hash_done_i) begin
                outstanding_q <= outstanding_q + 6'd1;
            end else if (!alloc && hash_done_i && (outstanding_q != 6'd0)) begin
                outstanding_q <= outstanding_q - 6'd1;
            end

            // New error events win over a same-cycle clear.
            err_q <= (status_clear_i ? 2'b00 : err_q) |
                     {seed_req && !seed_ok, hash_done_i && (outstanding_q == 6'd0)};
        end
    end

    assign msg_in_ready_o       = ready;
    assign msg_out_data_o       = msg_out_data_q;
    assign msg_out_id_o         = msg_out_id_q;
    assign msg_out_last_o       = msg_out_last_q;
    assign msg_out_valid_o      = msg_out_valid_q;
    assign id_out_o             = id_out_q;
    assign id_out_last_o        = 1'b1;
    assign id_out_valid_o       = id_out_valid_q;
    assign status_next_id_o     = next_id_q;
    assign status_outstanding_o = outstanding_q;
    assign status_err_o         = err_q;

endmodule

// File: doc/sha256_id_issuer.md
# sha256_id_issuer

Packet ID issuer and credit controller at the head of the SHA-256 pipeline. It sits between the message source and the hash engine. For each incoming message packet it allocates a 6-bit wrapping packet ID and tags every block of the packet with that ID on the way to the hash engine. It also pushes the same ID once into the ID buffer FIFO that feeds the ID validator. An outstanding-packet credit counter, returned by validator output handshakes, bounds IDs in flight so that the validator's MSB-based wrap comparison stays unambiguous.

## Interface
- MAX_OUTSTANDING, 31, maximum packets issued but not yet completed; legal range 1..31.
- clk  in  1  clock, all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low freezes all state
- sync_rst  in  1  synchronous local reset, same effect as nrst at next edge
- cfg_seed  in  6  ID to load as next allocated ID
- cfg_seed_load  in  1  single-cycle load request for cfg_seed
- msg_in_data  in  512  message block
- msg_in_last  in  1  final block of packet
- msg_in_valid  in  1  input valid
- msg_in_ready  out  1  input ready, combinational from registered state
- msg_out_data  out  512  registered message block to hash engine
- msg_out_id  out  6  packet ID of msg_out_data
- msg_out_last  out  1  final block of packet
- msg_out_valid  out  1  output valid
- msg_out_ready  in  1  hash engine ready
- id_out  out  6  allocated ID to ID buffer FIFO
- id_out_last  out  1  constant 1 (one-beat packets)
- id_out_valid  out  1  ID valid
- id_out_ready  in  1  ID buffer ready
- hash_done  in  1  pulse per validator hash_out handshake; returns one credit
- status_next_id  out  6  next ID to be allocated
- status_outstanding  out  6  packets in flight
- status_err  out  2  bit0 credit underflow, bit1 seed load rejected; sticky
- status_clear  in  1  clears status_err

## Operation
- States: IDLE (awaiting first block of a packet) and STREAM (mid-packet).
- Reset values: all outputs 0, except id_out_last = 1. State is IDLE, next_id = 0, outstanding = 0, and the internal current ID = 0.
- slot_free is true when msg_out_valid = 0 or msg_out_ready = 1.
- In IDLE, msg_in_ready = en & slot_free & (outstanding < MAX_OUTSTANDING) & (!id_out_valid | id_out_ready).
- In STREAM, msg_in_ready = en & slot_free.
- First-block accept in IDLE:
  - Load msg_out_data, msg_out_last and msg_out_id = next_id; assert msg_out_valid.
  - Set id_out = next_id and assert id_out_valid.
  - Increment next_id modulo 64 (63 → 0) and increment outstanding.
  - If msg_in_last = 0, go to STREAM; otherwise stay in IDLE.
- Accept in STREAM: load the block tagged with the current ID. Return to IDLE when msg_in_last = 1.
- If there is no accept and msg_out_ready = 1, clear msg_out_valid.
- If id_out_ready = 1 and no new allocation occurs, clear id_out_valid.
- Valids, once asserted, hold with stable data until handshake. They never drop while en is low.
- hash_done:
  - When outstanding > 0, decrement outstanding.
  - Allocation and hash_done in the same cycle leave outstanding unchanged.
  - hash_done with outstanding = 0 leaves the count at 0 and sets status_err[0].
- cfg_seed_load:
  - Accepted only when state = IDLE and outstanding = 0 and id_out_valid = 0 and msg_out_valid = 0; then next_id ← cfg_seed.
  - Otherwise ignored, and status_err[1] is set.
  - A load takes priority over an allocation in the same cycle, so that cycle has no msg_in accept (ready forced low).
- status_clear clears status_err. Any error event in the same cycle wins, and its bit stays set.
- en low:
  - msg_in_ready is 0; state, counters and all outputs hold.
  - hash_done, cfg_seed_load and status_clear are ignored.
- sync_rst or nrst mid-packet: return to reset values immediately. nrst is asynchronous; sync_rst takes effect at the next edge. Any partial packet is discarded.

## Timing
- msg_in → msg_out latency is 1 cycle. id_out_valid rises in the same cycle as the first-block msg_out_valid.
- Full throughput is one block per cycle while msg_out_ready = 1.
- A back-to-back packet's first block is accepted in the cycle after the previous last block, provided the credit and ID slot conditions hold.
- A credit returned by hash_done is usable for allocation in the next cycle.
- Because ready is combinational, no input is accepted when en is low.

## Test plan
- Reset, then send three 1-block packets with ready held high:
  - msg_out_id = 0, 1, 2 on consecutive cycles, with matching id_out.
  - status_outstanding = 3.
- Send a 4-block packet after seed load 0x3F, then a 1-block packet:
  - All 4 blocks tagged 0x3F; the next packet is tagged 0x00 (wrap).
  - id_out is pulsed twice in total.
- MAX_OUTSTANDING = 31: issue 31 packets without hash_done:
  - msg_in_ready stays 0 in IDLE.
  - One hash_done pulse lets the 32nd packet be accepted the next cycle.
- Hold id_out_ready low after one allocation:
  - The second packet's first block stalls.
  - A mid-packet block of the first packet still flows.
  - Releasing id_out_ready allows the second packet.
- Error paths:
  - hash_done with outstanding = 0 → status_err = 01.
  - cfg_seed_load mid-packet → status_err = 11, next_id unchanged.
  - status_clear → status_err = 00.
- Drop en for 5 cycles mid-stream with msg_out_ready low:
  - All outputs frozen, msg_out_valid held, no accepts.
  - Traffic resumes unaltered when en returns.
